// File: rtl/scs8hd_arb_pkg.sv
// Shared types and constants for the round-robin arbiter slice.
package scs8hd_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_MAX_HOLD = 15;

  // Ceiling log2, used to size the grant index.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/scs8hd_rrarb4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface scs8hd_rrarb4_if
  import scs8hd_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = clog2(N_REQ)
);

  logic [N_REQ-1:0] REQ;
  logic             LAST;
  logic [N_REQ-1:0] GNT;
  logic             GNT_VLD;
  logic [ID_W-1:0]  GNT_ID;
  logic             ANY_REQ;
  logic             TIMEOUT;

  modport master (
    output REQ, LAST,
    input  GNT, GNT_VLD, GNT_ID, ANY_REQ, TIMEOUT
  );

  modport slave (
    input  REQ, LAST,
    output GNT, GNT_VLD, GNT_ID, ANY_REQ, TIMEOUT
  );

endinterface

// File: rtl/scs8hd_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after
// i_ptr, wrapping at N_REQ (not at 2**ID_W).
module scs8hd_rr_pick
  import scs8hd_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_found
);

  // Scan N_REQ candidates starting at the pointer; the first hit wins.
  always_comb begin
    int j;
    j       = 0;
    o_pick  = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!o_found && i_req[j[ID_W-1:0]]) begin
        o_found             = 1'b1;
        o_pick[j[ID_W-1:0]] = 1'b1;
        o_idx               = j[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/scs8hd_rrarb4.sv
// Round-robin arbiter with hold-until-release grants and a watchdog that
// forces rotation after MAX_HOLD consecutive cycles (0 disables it).
module scs8hd_rrarb4
  import scs8hd_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int HOLD_W   = 4,
  parameter int ID_W     = clog2(N_REQ)
) (
  input logic            CLK,
  input logic            RESET,
  scs8hd_rrarb4_if.slave arb
);

  arb_state_t        r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic [ID_W-1:0]   r_gnt_id;
  logic [ID_W-1:0]   r_ptr;
  logic              r_vld;
  logic              r_timeout;
  logic [HOLD_W-1:0] r_cnt;

  logic [ID_W-1:0]   w_id_inc;
  logic [ID_W-1:0]   w_pick_ptr;
  logic [ID_W-1:0]   w_pick_idx;
  logic [N_REQ-1:0]  w_pick;
  logic              w_found;
  logic              w_rel_last;
  logic              w_rel_drop;
  logic              w_rel_wd;
  logic              w_release;
  logic              w_cnt_sat;

  // Pointer after a release: one past the grantee, wrapping at N_REQ.
  assign w_id_inc   = (r_gnt_id == ID_W'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
  // On release the new pointer is used in the same edge, so the releasing
  // requester naturally drops to lowest priority.
  assign w_pick_ptr = (r_state == ARB_GRANT) ? w_id_inc : r_ptr;

  assign w_rel_last = arb.LAST;
  assign w_rel_drop = ~arb.REQ[r_gnt_id];
  assign w_rel_wd   = (MAX_HOLD != 0) && (r_cnt == HOLD_W'(MAX_HOLD));
  assign w_release  = w_rel_last | w_rel_drop | w_rel_wd;
  assign w_cnt_sat  = &r_cnt;

  scs8hd_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req   (arb.REQ),
    .i_ptr   (w_pick_ptr),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  // Arbitration FSM with registered grant, index, hold counter and timeout.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_ptr     <= '0;
      r_vld     <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state  <= ARB_GRANT;
            r_gnt    <= w_pick;
            r_gnt_id <= w_pick_idx;
            r_vld    <= 1'b1;
            r_cnt    <= HOLD_W'(1);
          end
        end
        ARB_GRANT: begin
          if (w_release) begin
            r_ptr     <= w_id_inc;
            // Only a pure watchdog release is reported as a timeout.
            r_timeout <= w_rel_wd & ~w_rel_last & ~w_rel_drop;
            if (w_found) begin
              r_gnt    <= w_pick;
              r_gnt_id <= w_pick_idx;
              r_cnt    <= HOLD_W'(1);
            end else begin
              r_state  <= ARB_IDLE;
              r_gnt    <= '0;
              r_gnt_id <= '0;
              r_vld    <= 1'b0;
              r_cnt    <= '0;
            end
          end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign arb.GNT     = r_gnt;
  assign arb.GNT_VLD = r_vld;
  assign arb.GNT_ID  = r_gnt_id;
  assign arb.TIMEOUT = r_timeout;
  assign arb.ANY_REQ = |arb.REQ;

endmodule
